// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot-time program loader feeding the CPU instruction memory.
// Accepts a byte stream (LEN_HI, LEN_LO, N*4 payload bytes big-endian, XOR CSUM),
// writes each assembled word to consecutive word addresses from 0, and keeps the
// CPU in reset until a checksum-verified image has been written.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader can accept a byte (0 while reset is high)
//   im_we      one-cycle instruction-memory write strobe
//   im_addr    instruction-memory word address
//   im_data    instruction word
//   cpu_reset  CPU held in reset until the image is verified
//   done       image loaded and verified
//   error      image rejected
module imem_boot_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StDone,
        StError
    } state_e;

    localparam logic [ADDR_WIDTH:0] WordOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [7:0]            csum_q, csum_d;
    logic [23:0]           asm_q, asm_d;
    logic                  im_we_q, im_we_d;
    logic [ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
    logic [31:0]           im_data_q, im_data_d;

    logic       accept;
    logic [15:0] len_full;

    assign len_full = {len_hi_q, in_data};
    assign accept   = in_valid && in_ready;

    // in_ready depends on reset combinationally so nothing is offered as
    // accepted while reset is held.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            in_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
                       (state_q == StData)  || (state_q == StCsum);
        end
    end

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        asm_d      = asm_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_data_d  = im_data_q;

        if (accept) begin
            unique case (state_q)
                StLenHi: begin
                    len_hi_d = in_data;
                    state_d  = StLenLo;
                end
                StLenLo: begin
                    if (len_full == 16'd0 || 32'(len_full) > MAX_WORDS) begin
                        state_d = StError;
                    end else begin
                        len_d      = len_full[ADDR_WIDTH:0];
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        csum_d     = '0;
                        state_d    = StData;
                    end
                end
                StData: begin
                    asm_d      = {asm_q[15:0], in_data};
                    csum_d     = csum_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                        im_data_d  = {asm_q, in_data};
                        word_cnt_d = word_cnt_q + WordOne;
                        if (word_cnt_q + WordOne == len_q) begin
                            state_d = StCsum;
                        end
                    end
                end
                StCsum: begin
                    state_d = (in_data == csum_q) ? StDone : StError;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StLenHi;
            len_hi_q   <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            asm_q      <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            asm_q      <= asm_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_data_q  <= im_data_d;
        end
    end

    assign im_we     = im_we_q;
    assign im_addr   = im_addr_q;
    assign im_data   = im_data_q;
    assign done      = (state_q == StDone);
    assign error     = (state_q == StError);
    assign cpu_reset = (state_q != StDone);

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [31:0] im_data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_WIDTH(10), .MAX_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    int tests = 0;
    int fails = 0;

    // Observed writes and longest run of consecutive im_we cycles.
    wr_t wr_q[$];
    int  run_len = 0;
    int  max_run = 0;

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_q.push_back('{addr: int'(im_addr), data: im_data});
            run_len = run_len + 1;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    // Reference model results.
    wr_t        exp_q[$];
    bit         exp_done;
    bit         exp_err;
    logic [7:0] stim[$];

    // Interpret a complete stream by the format rules.
    task automatic build_model(input logic [7:0] b[$]);
        int         n;
        logic [7:0] x;
        exp_q.delete();
        n = int'(b[0]) * 256 + int'(b[1]);
        if (n == 0 || n > 1024) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{addr: k, data: {b[2+4*k], b[3+4*k], b[4+4*k], b[5+4*k]}});
            for (int j = 0; j < 4; j++) x = x ^ b[2+4*k+j];
        end
        exp_done = (b[2+4*n] == x);
        exp_err  = !exp_done;
    endtask

    // Build a random image of n words; bad selects a wrong checksum.
    task automatic make_image(input int n, input bit bad);
        logic [7:0] x;
        logic [7:0] v;
        stim.delete();
        stim.push_back(8'(n >> 8));
        stim.push_back(8'(n));
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            v = 8'($urandom);
            stim.push_back(v);
            x = x ^ v;
        end
        stim.push_back(bad ? x ^ 8'(1 << $urandom_range(7, 0)) : x);
    endtask

    task automatic fixed_image(input logic [7:0] csum);
        stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h08, 8'h40, 8'h20, csum};
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        wr_q.delete();
        run_len = 0;
        max_run = 0;
    endtask

    // mode 0: full rate, 1: valid every third cycle, 2: random bubbles.
    // Stops early if the loader drops in_ready (terminal state).
    task automatic send(input logic [7:0] b[$], input int mode);
        int i   = 0;
        int cyc = 0;
        while (i < b.size()) begin
            @(negedge clk);
            in_valid = (mode == 0) || (mode == 1 && cyc % 3 == 0) ||
                       (mode == 2 && $urandom_range(1, 0) == 1);
            in_data  = in_valid ? b[i] : 8'($urandom);
            if (in_valid && !in_ready) break;
            if (in_valid) i++;
            cyc++;
            if (cyc > 5000) begin
                tests++;
                fails++;
                $display("FAIL send_budget: sent %0d bytes, required %0d", i, b.size());
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #3;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        tests++; if (im_we !== 1'b0) begin fails++; $display("FAIL rst_im_we: got %b want 0", im_we); end
        tests++; if (im_addr !== 10'd0) begin fails++; $display("FAIL rst_im_addr: got %0d want 0", im_addr); end
        tests++; if (im_data !== 32'd0) begin fails++; $display("FAIL rst_im_data: got %h want 0", im_data); end
        tests++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
        tests++; if ({done, error} !== 2'b00) begin fails++; $display("FAIL rst_done_err: got %b want 00", {done, error}); end
        do_reset();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_load();
        do_reset();
        fixed_image(8'h44);
        build_model(stim);
        send(stim, 0);
        tests++; if (wr_q.size() !== 2) begin fails++; $display("FAIL load_nwr: got %0d want 2", wr_q.size()); end
        tests++; if (wr_q.size() > 0 && (wr_q[0].addr !== 0 || wr_q[0].data !== 32'h20080005)) begin
            fails++; $display("FAIL load_wr0: got %0d/%h want 0/20080005", wr_q[0].addr, wr_q[0].data); end
        tests++; if (wr_q.size() > 1 && (wr_q[1].addr !== 1 || wr_q[1].data !== 32'h01084020)) begin
            fails++; $display("FAIL load_wr1: got %0d/%h want 1/01084020", wr_q[1].addr, wr_q[1].data); end
        tests++; if ({done, error, cpu_reset, in_ready} !== 4'b1000) begin
            fails++; $display("FAIL load_status: got %b want 1000", {done, error, cpu_reset, in_ready}); end
        tests++; if (im_addr !== 10'd1 || im_data !== 32'h01084020) begin
            fails++; $display("FAIL load_hold: got %0d/%h want 1/01084020", im_addr, im_data); end
        tests++; if (max_run !== 1) begin fails++; $display("FAIL load_we_width: got %0d want 1", max_run); end
        // Extra bytes after DONE are ignored.
        stim = '{8'h00, 8'h01};
        send(stim, 0);
        tests++; if (wr_q.size() !== 2 || done !== 1'b1) begin
            fails++; $display("FAIL done_ignore: got %0d/%b want 2/1", wr_q.size(), done); end
    endtask

    task automatic test_bad_len(input logic [7:0] hi, input logic [7:0] lo);
        do_reset();
        stim = '{hi, lo};
        send(stim, 0);
        tests++; if (wr_q.size() !== 0) begin fails++; $display("FAIL badlen_%h%h_wr: got %0d want 0", hi, lo, wr_q.size()); end
        tests++; if ({error, done, cpu_reset, in_ready} !== 4'b1010) begin
            fails++; $display("FAIL badlen_%h%h_status: got %b want 1010", hi, lo, {error, done, cpu_reset, in_ready}); end
    endtask

    task automatic test_bad_csum();
        do_reset();
        fixed_image(8'h45);
        send(stim, 0);
        tests++; if (wr_q.size() !== 2) begin fails++; $display("FAIL badcsum_nwr: got %0d want 2", wr_q.size()); end
        tests++; if (wr_q.size() > 1 && wr_q[1].data !== 32'h01084020) begin
            fails++; $display("FAIL badcsum_wr1: got %h want 01084020", wr_q[1].data); end
        tests++; if ({error, done, cpu_reset} !== 3'b101) begin
            fails++; $display("FAIL badcsum_status: got %b want 101", {error, done, cpu_reset}); end
    endtask

    task automatic test_bubbles();
        do_reset();
        fixed_image(8'h44);
        build_model(stim);
        send(stim, 1);
        tests++; if (wr_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL bubble_nwr: got %0d want %0d", wr_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
            tests++; if (wr_q[k].addr !== exp_q[k].addr || wr_q[k].data !== exp_q[k].data) begin
                fails++; $display("FAIL bubble_wr%0d: got %0d/%h want %0d/%h", k, wr_q[k].addr,
                                  wr_q[k].data, exp_q[k].addr, exp_q[k].data); end
        end
        tests++; if (max_run !== 1) begin fails++; $display("FAIL bubble_we_width: got %0d want 1", max_run); end
        tests++; if ({done, cpu_reset} !== 2'b10) begin
            fails++; $display("FAIL bubble_status: got %b want 10", {done, cpu_reset}); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] part[$];
        do_reset();
        fixed_image(8'h44);
        build_model(stim);
        part = stim[0:7];
        send(part, 0);
        #2 reset = 1'b1;
        #1;
        tests++; if ({in_ready, im_we, cpu_reset, done, error} !== 5'b00100) begin
            fails++; $display("FAIL mid_rst_flags: got %b want 00100", {in_ready, im_we, cpu_reset, done, error}); end
        tests++; if (im_addr !== 10'd0 || im_data !== 32'd0) begin
            fails++; $display("FAIL mid_rst_bus: got %0d/%h want 0/0", im_addr, im_data); end
        do_reset();
        send(stim, 0);
        tests++; if (wr_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL mid_nwr: got %0d want %0d", wr_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
            tests++; if (wr_q[k].addr !== exp_q[k].addr || wr_q[k].data !== exp_q[k].data) begin
                fails++; $display("FAIL mid_wr%0d: got %0d/%h want %0d/%h", k, wr_q[k].addr,
                                  wr_q[k].data, exp_q[k].addr, exp_q[k].data); end
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL mid_done: got %b want 1", done); end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 20; it++) begin
            do_reset();
            if ($urandom_range(9, 0) == 0) begin
                n = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(65535, 1025));
                stim = '{8'(n >> 8), 8'(n)};
            end else begin
                n = int'($urandom_range(8, 1));
                make_image(n, $urandom_range(2, 0) == 0);
            end
            build_model(stim);
            send(stim, 2);
            tests++; if (wr_q.size() !== exp_q.size()) begin
                fails++; $display("FAIL rnd%0d_nwr: got %0d want %0d", it, wr_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
                tests++; if (wr_q[k].addr !== exp_q[k].addr || wr_q[k].data !== exp_q[k].data) begin
                    fails++; $display("FAIL rnd%0d_wr%0d: got %0d/%h want %0d/%h", it, k, wr_q[k].addr,
                                      wr_q[k].data, exp_q[k].addr, exp_q[k].data); end
            end
            tests++; if ({done, error, cpu_reset} !== {exp_done, exp_err, !exp_done}) begin
                fails++; $display("FAIL rnd%0d_status: got %b want %b", it, {done, error, cpu_reset},
                                  {exp_done, exp_err, !exp_done}); end
            tests++; if (max_run > 1) begin fails++; $display("FAIL rnd%0d_we_width: got %0d want 1", it, max_run); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_bad_len(8'h00, 8'h00);
        test_bad_len(8'h04, 8'h01);
        test_bad_csum();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time program loader that sits directly upstream of the CPU's instruction memory. It accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instruction words, and writes them into consecutive instruction-memory word addresses starting at 0. It holds the CPU in reset until a complete, checksum-verified image has been written. Only a correct image releases the CPU.

## Interface
- ADDR_WIDTH, 10: instruction-memory word-address width, matching the instruction memory's word-address port.
- MAX_WORDS, 1024: largest accepted image length, in words.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte; forced to 0 while reset is high.
- im_we  output  1  one-cycle write strobe to the instruction memory.
- im_addr  output  ADDR_WIDTH  word address for the write.
- im_data  output  32  instruction word to write.
- cpu_reset  output  1  holds the CPU in reset; 1 until DONE.
- done  output  1  image loaded and verified.
- error  output  1  image rejected.

## Operation
- Byte accept: a byte is taken on a rising edge where in_valid && in_ready. No other edge consumes data.
- Stream format:
  - LEN: 2 bytes, word count N, big-endian.
  - Payload: N×4 bytes, each word most-significant byte first.
  - CSUM: 1 byte, the XOR of all payload bytes. The length bytes are excluded.
- States:
  - LEN_HI: take the length high byte, go to LEN_LO.
  - LEN_LO: take the length low byte.
    - If N == 0 or N > MAX_WORDS, go to ERROR.
    - Otherwise clear the word counter, byte counter and checksum, then go to DATA.
  - DATA: shift each byte into a 32-bit assembly register and XOR it into the running checksum.
    - On the 4th byte of a word, latch the word and its address, then pulse a write.
    - After the 4th byte of word N-1, go to CSUM.
  - CSUM: take one byte. If it equals the running checksum go to DONE, otherwise go to ERROR.
  - DONE: in_ready=0, done=1, cpu_reset=0. Terminal until reset.
  - ERROR: in_ready=0, error=1, cpu_reset=1. Terminal until reset.
- in_ready is 1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 otherwise.
- Word addresses: the k-th word (k counting from 0) is written to address k. The address counter is ADDR_WIDTH+1 bits wide so it never wraps inside a legal image.
- Memory contents are never cleared. After an error, words already written stay in memory, but the CPU stays in reset.
- Input bytes that arrive while in DONE or ERROR are ignored; in_ready is 0.

## Timing
- Reset values: state=LEN_HI, in_ready=0 while reset is high, im_we=0, im_addr=0, im_data=0, cpu_reset=1, done=0, error=0, all counters and the checksum 0.
- Write latency: im_we is high for exactly the one cycle after the edge that accepted the 4th byte of a word. im_addr and im_data are stable during that cycle and hold their values afterward.
- Back-to-back writes: at full rate, words are accepted every 4 cycles, so im_we pulses every 4 cycles. The loader never stalls the stream; in_ready stays 1 throughout DATA.
- Bubbles: gaps in in_valid stall assembly and have no other effect.
- Overlap: the last write pulse and acceptance of the CSUM byte may fall in the same cycle; both must complete.
- Release: done rises and cpu_reset falls on the edge that accepts a matching CSUM byte, so the CPU's first fetch is at address 0 on the next edge.
- error rises on the edge that accepts the offending byte, i.e. the length low byte or the CSUM byte.
- Reset mid-operation: asynchronous return to LEN_HI with all reset values. A partial word is discarded, cpu_reset goes back to 1, and memory is untouched.

## Test plan
- Load 2 words: stream 00 02 20 08 00 05 01 08 40 20 44 at full rate.
  - im_we pulses with (addr 0, 0x20080005), then (addr 1, 0x01084020).
  - done=1 and cpu_reset=0 after byte 0x44.
  - in_ready=0 afterward.
- Stream 00 00: error=1 after the second byte, no im_we, cpu_reset stays 1.
- Stream 04 01: N=1025 exceeds the limit, so error=1 with no writes.
- Same 2-word image as the first case with checksum 0x45 instead of 0x44:
  - Both writes still occur.
  - error=1, done=0, cpu_reset=1.
- Same 2-word image with in_valid toggling high every third cycle:
  - Identical writes and completion as the first case.
  - Each im_we is exactly one cycle wide.
- Assert reset after 6 payload bytes, then resend the full 2-word image:
  - After reset, outputs are at their reset values.
  - Second load writes addresses 0 and 1 with the correct data and reaches done=1.
